// File: rtl/uart_wrapper.sv
// uart_wrapper: 8N1 UART front end. Collects NUM_IN bytes from the host into a
// local buffer, then echoes them back in order followed by an 8-bit running sum.
module uart_wrapper #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int NUM_IN       = 31,
    parameter int NUM_OUT      = 32,
    parameter int DATA_W       = 8
) (
    input  logic sysclk,
    input  logic reset,
    input  logic uart_txd_in,
    output logic uart_rxd_out
);

    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(NUM_OUT);
    localparam int IDX_W = $clog2(NUM_IN);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int TX_N  = DATA_W + 2;
    localparam int TX_BW = $clog2(TX_N);

    localparam logic [CLK_W-1:0] BIT_END  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] HALF_END = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(NUM_OUT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [TX_BW-1:0] TX_LAST  = TX_BW'(TX_N - 1);

    // RX_WAIT doubles as the framing-error state: bad stop bit seen, byte dropped
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic {RECV, SEND} state_t;

    logic [1:0]        r_sync;
    rx_state_t         r_rx_state;
    logic [CLK_W-1:0]  r_rx_clk;
    logic [BIT_W-1:0]  r_rx_bit;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_vld;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_buf [NUM_IN];
    logic              r_tx_busy;
    logic [CLK_W-1:0]  r_tx_clk;
    logic [TX_BW-1:0]  r_tx_bit;
    logic [TX_N-1:0]   r_tx_shift;
    logic              r_txd;

    logic              w_rx;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_byte_cur;
    logic [DATA_W-1:0] w_byte_nxt;

    assign w_rx       = r_sync[1];
    assign w_cnt_nxt  = r_cnt + 1'b1;
    // The last slot of the outgoing frame is the checksum, not a buffer entry
    assign w_byte_cur = (r_cnt == LAST_OUT) ? r_sum : r_buf[r_cnt[IDX_W-1:0]];
    assign w_byte_nxt = (w_cnt_nxt == LAST_OUT) ? r_sum : r_buf[w_cnt_nxt[IDX_W-1:0]];
    assign uart_rxd_out = r_txd;

    // RX: synchronise the host line, find start edges, sample mid-bit, check stop bit
    always_ff @(posedge sysclk) begin
        r_rx_vld <= 1'b0;
        if (reset) begin
            r_sync     <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_clk   <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_sync <= {r_sync[0], uart_txd_in};
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_clk <= '0;
                    r_rx_bit <= '0;
                    if (!w_rx) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_rx_clk == HALF_END) begin
                        r_rx_clk   <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_clk == BIT_END) begin
                        r_rx_clk   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_W-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == LAST_BIT) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_clk == BIT_END) begin
                        r_rx_clk <= '0;
                        if (w_rx) begin
                            r_rx_vld   <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_WAIT;
                        end
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (w_rx) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sequencer: buffer and sum bytes in RECV, serialise the echo plus checksum in SEND
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state   <= RECV;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_txd     <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_clk  <= '0;
            r_tx_bit  <= '0;
        end else begin
            case (r_state)
                RECV: begin
                    r_txd     <= 1'b1;
                    r_tx_busy <= 1'b0;
                    if (r_rx_vld) begin
                        r_buf[r_cnt[IDX_W-1:0]] <= r_rx_shift;
                        r_sum <= r_sum + r_rx_shift;
                        if (r_cnt == LAST_IN) begin
                            r_cnt   <= '0;
                            r_state <= SEND;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                SEND: begin
                    if (!r_tx_busy) begin
                        r_tx_busy  <= 1'b1;
                        r_tx_shift <= {1'b1, w_byte_cur, 1'b0};
                        r_txd      <= 1'b0;
                        r_tx_clk   <= '0;
                        r_tx_bit   <= '0;
                    end else if (r_tx_clk != BIT_END) begin
                        r_tx_clk <= r_tx_clk + 1'b1;
                    end else begin
                        r_tx_clk <= '0;
                        if (r_tx_bit != TX_LAST) begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= {1'b1, r_tx_shift[TX_N-1:1]};
                            r_txd      <= r_tx_shift[1];
                        end else if (r_cnt == LAST_OUT) begin
                            r_state   <= RECV;
                            r_cnt     <= '0;
                            r_sum     <= '0;
                            r_tx_busy <= 1'b0;
                            r_txd     <= 1'b1;
                        end else begin
                            // next start bit directly follows this stop bit
                            r_cnt      <= w_cnt_nxt;
                            r_tx_shift <= {1'b1, w_byte_nxt, 1'b0};
                            r_txd      <= 1'b0;
                            r_tx_bit   <= '0;
                        end
                    end
                end
                default: r_state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wrapper.sv
// tb_uart_wrapper: drives host frames into uart_wrapper and decodes the echoed
// frame, comparing every byte and the trailing checksum against hand values.
module tb_uart_wrapper;

    localparam int CPB      = 16;
    localparam int NUM_IN   = 31;
    localparam int NUM_OUT  = 32;
    localparam int HALF_CLK = 40;
    localparam int HOST_BIT = 1281;   // one unit slower than 16 clocks of 80

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic uart_txd_in = 1'b1;
    logic uart_rxd_out;

    uart_wrapper #(
        .CLKS_PER_BIT (CPB),
        .NUM_IN       (NUM_IN),
        .NUM_OUT      (NUM_OUT),
        .DATA_W       (8)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .uart_txd_in  (uart_txd_in),
        .uart_rxd_out (uart_rxd_out)
    );

    always #(HALF_CLK) sysclk = ~sysclk;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] sum;
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] host_b [NUM_IN];
    int         host_n;
    logic [7:0] exp_b [NUM_OUT];
    logic [7:0] got_b [NUM_OUT];
    int         got_n;
    int         tx_bad;
    bit         timed_out;
    int         n_pass  = 0;
    int         n_total = 0;
    int         lows;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_txd_in = 1'b0;
        #(HOST_BIT);
        for (int i = 0; i < 8; i++) begin
            uart_txd_in = b[i];
            #(HOST_BIT);
        end
        uart_txd_in = stop;
        #(HOST_BIT);
        uart_txd_in = 1'b1;
        if (!stop) #(HOST_BIT);
    endtask

    task automatic send_host();
        for (int i = 0; i < host_n; i++) send_byte(host_b[i], 1'b1);
    endtask

    task automatic quiet(input int cycles, output int low_cnt);
        low_cnt = 0;
        repeat (cycles) begin
            @(negedge sysclk);
            if (uart_rxd_out !== 1'b1) low_cnt++;
        end
    endtask

    task automatic collect();
        got_n = 0;
        timed_out = 1'b0;
        tx_bad = 0;
        for (int k = 0; k < NUM_OUT; k++) got_b[k] = 'x;
        for (int k = 0; k < NUM_OUT; k++) begin
            int w = 0;
            int lim = (k == 0) ? 8000 : 4 * CPB;
            logic [7:0] b;
            while (uart_rxd_out !== 1'b0 && w < lim) begin
                @(negedge sysclk);
                w++;
            end
            if (uart_rxd_out !== 1'b0) begin
                timed_out = 1'b1;
                return;
            end
            repeat (CPB / 2) @(negedge sysclk);
            if (uart_rxd_out !== 1'b0) tx_bad++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge sysclk);
                b[i] = uart_rxd_out;
            end
            repeat (CPB) @(negedge sysclk);
            if (uart_rxd_out !== 1'b1) tx_bad++;
            got_b[k] = b;
            got_n++;
        end
    endtask

    task automatic run_frame(input string tag);
        fork
            send_host();
            collect();
        join
        check({tag, " timeout"}, 32'(timed_out), 32'd0);
        check({tag, " byte count"}, got_n, NUM_OUT);
        check({tag, " tx framing"}, tx_bad, 0);
        for (int i = 0; i < NUM_OUT; i++)
            check($sformatf("%s byte %0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
        repeat (3 * CPB) @(negedge sysclk);
    endtask

    initial begin
        #(100000 * 2 * HALF_CLK);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{base: 8'h00, step: 8'h01, sum: 8'hD1};
        vecs[1] = '{base: 8'h80, step: 8'h03, sum: 8'hF3};
        vecs[2] = '{base: 8'h10, step: 8'h11, sum: 8'hD1};

        // reset and idle line
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        check("reset txd", 32'(uart_rxd_out), 32'd1);
        quiet(100 * CPB, lows);
        check("idle no tx", lows, 0);

        // single byte must not trigger a reply, nor must a short glitch
        send_byte(8'hA5, 1'b1);
        quiet(20 * CPB, lows);
        check("one byte no tx", lows, 0);
        @(negedge sysclk);
        uart_txd_in = 1'b0;
        #50;
        uart_txd_in = 1'b1;
        quiet(5 * CPB, lows);
        check("glitch no tx", lows, 0);

        // 30 more bytes complete the frame started by 0xA5
        host_n = 30;
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 30; i++) begin
            host_b[i]    = 8'(i + 1);
            exp_b[i + 1] = 8'(i + 1);
        end
        exp_b[31] = 8'h76;
        run_frame("a5 frame");

        // table-driven full frames
        for (int v = 0; v < 3; v++) begin
            host_n = NUM_IN;
            for (int i = 0; i < NUM_IN; i++) begin
                host_b[i] = vecs[v].base + vecs[v].step * 8'(i);
                exp_b[i]  = host_b[i];
            end
            exp_b[NUM_OUT - 1] = vecs[v].sum;
            run_frame($sformatf("vec%0d", v));
        end

        // bad stop bit: byte discarded, next 31 bytes form the frame
        send_byte(8'h55, 1'b0);
        quiet(3 * CPB, lows);
        check("ferr no tx", lows, 0);
        host_n = NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
            host_b[i] = 8'(8'h20 + i);
            exp_b[i]  = host_b[i];
        end
        exp_b[NUM_OUT - 1] = 8'hB1;
        run_frame("after ferr");

        // reset mid-frame abandons the partial frame
        host_n = 10;
        for (int i = 0; i < 10; i++) host_b[i] = 8'h42;
        send_host();
        @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        check("mid reset txd", 32'(uart_rxd_out), 32'd1);
        host_n = NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
            host_b[i] = 8'hFF;
            exp_b[i]  = 8'hFF;
        end
        exp_b[NUM_OUT - 1] = 8'hE1;
        run_frame("ff frame");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
